// File: rtl/light_pen_detector_pkg.sv
// rtl/light_pen_detector_pkg.sv - shared defaults, FSM encodings and one-hot encoder for the light pen detector
package light_pen_detector_pkg;

    localparam int CLOCK_FREQ          = 20_000_000;
    localparam int DEF_BLANK_CYCLES    = 8;
    localparam int DEF_WINDOW_CYCLES   = 32;
    localparam int DEF_HIT_THRESH      = 24;
    // Key debounce targets 1 ms at CLOCK_FREQ.
    localparam int DEF_DEBOUNCE_CYCLES = CLOCK_FREQ / 1000;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_BLANK  = 3'd1;
    localparam logic [2:0] ST_SAMPLE = 3'd2;
    localparam logic [2:0] ST_DECIDE = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;

    function automatic logic [2:0] onehot_to_bin(input logic [7:0] oh);
        logic [2:0] b;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                b = b | 3'(i);
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/light_pen_detector_if.sv
// rtl/light_pen_detector_if.sv - scan/pen inputs and hit outputs of the light pen detector
interface light_pen_detector_if;

    logic       en;
    logic [7:0] led_row;
    logic [7:0] led_col;
    logic       pen_sense_raw;
    logic       pen_key_raw;
    logic       we;
    logic       hit_valid;
    logic [2:0] hit_row;
    logic [2:0] hit_col;
    logic       key_level;

    modport master (
        output en, led_row, led_col, pen_sense_raw, pen_key_raw,
        input  we, hit_valid, hit_row, hit_col, key_level
    );

    modport slave (
        input  en, led_row, led_col, pen_sense_raw, pen_key_raw,
        output we, hit_valid, hit_row, hit_col, key_level
    );

endinterface

// File: rtl/light_pen_detector_pen_debounce.sv
// rtl/light_pen_detector_pen_debounce.sv - 2-flop synchroniser plus stability counter for the pen key
module light_pen_detector_pen_debounce
    import light_pen_detector_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        // Count consecutive cycles of disagreement; any agreement restarts the count.
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/light_pen_detector.sv
// rtl/light_pen_detector.sv - decides the pen is over the lit pixel and issues the LED RAM write strobe
module light_pen_detector
    import light_pen_detector_pkg::*;
#(
    parameter int BLANK_CYCLES    = DEF_BLANK_CYCLES,
    parameter int WINDOW_CYCLES   = DEF_WINDOW_CYCLES,
    parameter int HIT_THRESH      = DEF_HIT_THRESH,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    light_pen_detector_if.slave  bus
);

    localparam int AW      = $clog2(WINDOW_CYCLES + 1);
    localparam int CNT_MAX = (BLANK_CYCLES > WINDOW_CYCLES) ? BLANK_CYCLES : WINDOW_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [7:0]    row_q, row_d;
    logic [7:0]    col_q, col_d;
    logic          sense_s1_q, sense_s1_d;
    logic          sense_s2_q, sense_s2_d;
    logic          we_q, we_d;
    logic          hit_valid_q, hit_valid_d;
    logic [2:0]    hit_row_q, hit_row_d;
    logic [2:0]    hit_col_q, hit_col_d;
    logic          key_level;
    logic          step;
    logic          pos_valid;

    light_pen_detector_pen_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.pen_key_raw),
        .level (key_level)
    );

    assign step      = {bus.led_row, bus.led_col} != {row_q, col_q};
    assign pos_valid = $onehot(bus.led_row) && $onehot(bus.led_col);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        row_d       = bus.led_row;
        col_d       = bus.led_col;
        sense_s1_d  = bus.pen_sense_raw;
        sense_s2_d  = sense_s1_q;
        we_d        = 1'b0;
        hit_valid_d = 1'b0;
        hit_row_d   = hit_row_q;
        hit_col_d   = hit_col_q;

        // A new pixel always restarts the window, abandoning any pending decision.
        if (!bus.en || !pos_valid) begin
            state_d = ST_IDLE;
        end else if (step) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_BLANK: begin
                    if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
                        state_d = ST_SAMPLE;
                        cnt_d   = '0;
                        acc_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_SAMPLE: begin
                    acc_d = acc_q + AW'(sense_s2_q);
                    if (cnt_q == CW'(WINDOW_CYCLES - 1)) begin
                        state_d = ST_DECIDE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_DECIDE: begin
                    state_d = ST_HOLD;
                    if (acc_q >= AW'(HIT_THRESH) && key_level) begin
                        we_d        = 1'b1;
                        hit_valid_d = 1'b1;
                        hit_row_d   = onehot_to_bin(row_q);
                        hit_col_d   = onehot_to_bin(col_q);
                    end
                end
                ST_IDLE, ST_HOLD: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            sense_s1_q  <= 1'b0;
            sense_s2_q  <= 1'b0;
            we_q        <= 1'b0;
            hit_valid_q <= 1'b0;
            hit_row_q   <= '0;
            hit_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            row_q       <= row_d;
            col_q       <= col_d;
            sense_s1_q  <= sense_s1_d;
            sense_s2_q  <= sense_s2_d;
            we_q        <= we_d;
            hit_valid_q <= hit_valid_d;
            hit_row_q   <= hit_row_d;
            hit_col_q   <= hit_col_d;
        end
    end

    assign bus.we        = we_q;
    assign bus.hit_valid = hit_valid_q;
    assign bus.hit_row   = hit_row_q;
    assign bus.hit_col   = hit_col_q;
    assign bus.key_level = key_level;

endmodule

// File: tb/tb_light_pen_detector.sv
// tb/tb_light_pen_detector.sv - directed self-checking bench for light_pen_detector
module tb_light_pen_detector;
    import light_pen_detector_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   we_cnt, first_we, hv_cnt, kl_cnt;

    always #5 clk = ~clk;

    light_pen_detector_if bus();

    light_pen_detector #(
        .BLANK_CYCLES    (2),
        .WINDOW_CYCLES   (8),
        .HIT_THRESH      (6),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_pixel(input logic [7:0] row, input logic [7:0] col,
                             input logic [31:0] sense_mask, input logic [31:0] key_mask,
                             input int dwell);
        bus.led_row = row;
        bus.led_col = col;
        we_cnt = 0; hv_cnt = 0; kl_cnt = 0; first_we = -1;
        for (int j = 0; j < dwell; j++) begin
            bus.pen_sense_raw = sense_mask[j];
            bus.pen_key_raw   = key_mask[j];
            tick();
            if (bus.we === 1'b1) begin
                we_cnt++;
                if (first_we < 0) first_we = j;
            end
            if (bus.hit_valid === 1'b1) hv_cnt++;
            if (bus.key_level === 1'b1) kl_cnt++;
        end
    endtask

    task automatic pixel(input string tag, input logic [7:0] row, input logic [7:0] col,
                         input logic [31:0] sense_mask, input logic [31:0] key_mask,
                         input int dwell, input int exp_we, input int exp_row, input int exp_col);
        run_pixel(row, col, sense_mask, key_mask, dwell);
        check({tag, "_we_count"}, we_cnt, exp_we);
        check({tag, "_hit_valid_count"}, hv_cnt, exp_we);
        if (exp_we == 1) check({tag, "_we_latency"}, first_we, 11);
        check({tag, "_hit_row"}, int'(bus.hit_row), exp_row);
        check({tag, "_hit_col"}, int'(bus.hit_col), exp_col);
    endtask

    initial begin
        rst = 1'b1;
        bus.en = 1'b1;
        bus.led_row = 8'h00;
        bus.led_col = 8'h00;
        bus.pen_sense_raw = 1'b0;
        bus.pen_key_raw = 1'b0;

        // Reset held with pen inputs toggling.
        for (int i = 0; i < 3; i++) begin
            bus.pen_sense_raw = (i % 2 == 0);
            bus.pen_key_raw   = (i % 2 != 0);
            tick();
            check("rst_we", int'(bus.we), 0);
            check("rst_hit_valid", int'(bus.hit_valid), 0);
        end
        check("rst_hit_row", int'(bus.hit_row), 0);
        check("rst_hit_col", int'(bus.hit_col), 0);
        check("rst_key_level", int'(bus.key_level), 0);
        check("rst_state", int'(dut.state_q), int'(ST_IDLE));

        rst = 1'b0;
        run_pixel(8'h00, 8'h00, 32'h0, 32'h0, 10);
        check("post_rst_no_we", we_cnt, 0);
        check("post_rst_state", int'(dut.state_q), int'(ST_IDLE));

        // Key press reaches key_level exactly 6 edges later (2 sync + 4 stable).
        bus.pen_key_raw = 1'b1;
        ticks(5);
        check("key_press_early", int'(bus.key_level), 0);
        tick();
        check("key_press_level", int'(bus.key_level), 1);

        pixel("hit",  8'h04, 8'h10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 20, 1, 2, 4);
        pixel("th6",  8'h01, 8'h80, 32'h0000_007E, 32'hFFFF_FFFF, 20, 1, 0, 7);
        pixel("th5",  8'h80, 8'h01, 32'h0000_003E, 32'hFFFF_FFFF, 20, 0, 0, 7);

        bus.pen_key_raw = 1'b0;
        ticks(6);
        check("key_release_level", int'(bus.key_level), 0);

        pixel("bounce", 8'h02, 8'h02, 32'hFFFF_FFFF, 32'h071C_71C7, 20, 0, 0, 7);
        check("bounce_key_level", kl_cnt, 0);

        bus.pen_key_raw = 1'b0;
        ticks(6);
        bus.pen_key_raw = 1'b1;
        ticks(5);
        check("stable_press_early", int'(bus.key_level), 0);
        tick();
        check("stable_press_level", int'(bus.key_level), 1);
        pixel("resume", 8'h10, 8'h08, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 20, 1, 4, 3);

        pixel("abort_old", 8'h20, 8'h40, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6, 0, 4, 3);
        pixel("abort_new", 8'h08, 8'h04, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 20, 1, 3, 2);

        // Disable mid-window.
        pixel("dis_pre", 8'h01, 8'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 0, 3, 2);
        check("dis_pre_state", int'(dut.state_q), int'(ST_SAMPLE));
        bus.en = 1'b0;
        tick();
        check("dis_state", int'(dut.state_q), int'(ST_IDLE));
        pixel("dis", 8'h01, 8'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 20, 0, 3, 2);

        // Non-one-hot column mid-window.
        bus.en = 1'b1;
        pixel("inv_pre", 8'h40, 8'h20, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 0, 3, 2);
        bus.led_col = 8'h18;
        tick();
        check("inv_state", int'(dut.state_q), int'(ST_IDLE));
        pixel("inv", 8'h40, 8'h18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 20, 0, 3, 2);

        pixel("recover", 8'h40, 8'h02, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 20, 1, 6, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/light_pen_detector.md
Name: light_pen_detector

Overview:
- Upstream of the LED driver. Produces the driver's `we` pulse: it decides that the light pen is over the pixel the scanner is lighting right now.
- Watches the scanner's one-hot row/column outputs and the pen photo-sensor. After each scan step it waits out the sensor latency, then counts sensor hits over a fixed window.
- If the pen key is held and enough samples hit, it pulses `we` while the scan still addresses that pixel. It also reports the encoded hit coordinate to the system state machine.

Parameters:
- BLANK_CYCLES, 8, cycles ignored after a scan step (sensor/LED rise latency).
- WINDOW_CYCLES, 32, cycles over which the synchronised pen sensor is sampled.
- HIT_THRESH, 24, minimum high samples in a window to declare a hit (1..WINDOW_CYCLES).
- DEBOUNCE_CYCLES, 20000, cycles pen key must be stable before its debounced level changes.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- en  in  1  detection enable from state machine (high in LIGHT/DRAW/ERASE/COLOR/WRITE)
- led_row  in  8  current scan row, one-hot
- led_col  in  8  current scan column, one-hot
- pen_sense_raw  in  1  asynchronous photo-sensor, high = light seen
- pen_key_raw  in  1  asynchronous pen button, high = pressed
- we  out  1  one-cycle write strobe to the LED RAM
- hit_valid  out  1  one-cycle strobe, coincident with every qualified hit
- hit_row  out  3  binary index of last hit row
- hit_col  out  3  binary index of last hit column
- key_level  out  1  debounced pen key level

Behaviour:
- Reset (rst high at a clk edge):
  - we=0, hit_valid=0, hit_row=0, hit_col=0, key_level=0.
  - Synchroniser flops cleared, debounce counter=0, sample counter=0, FSM=IDLE.
  - Registered copies of led_row/led_col are cleared to 0.
- Input conditioning:
  - pen_sense_raw and pen_key_raw each pass a 2-flop synchroniser.
  - key_level changes only after the synchronised key holds the opposite value for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
- Scan-step detect: "step" is true in a cycle where {led_row,led_col} differs from its value registered on the previous edge.
- Position valid: led_row and led_col are each exactly one-hot.
- FSM states: IDLE, BLANK, SAMPLE, DECIDE, HOLD.
- Transitions:
  - Any state, with step && en && position valid → BLANK, counter=0.
    - This has highest priority, so a step mid-BLANK/SAMPLE aborts the window and no we is issued for the old pixel.
  - Any state, with en=0 or position invalid → IDLE. While in IDLE, we and hit_valid stay 0.
  - BLANK → SAMPLE when counter reaches BLANK_CYCLES-1. The counter and the hit accumulator are both cleared.
  - SAMPLE: each cycle the accumulator adds the synchronised sensor bit. → DECIDE after WINDOW_CYCLES cycles.
    - Accumulator width is $clog2(WINDOW_CYCLES+1) and it cannot overflow.
  - DECIDE (one cycle) → HOLD.
    - If accumulator >= HIT_THRESH and key_level=1: we=1 and hit_valid=1 on the next edge, for exactly one cycle.
    - On that same edge, hit_row/hit_col load the binary encode of the registered led_row/led_col.
  - HOLD: waits for the next step; takes no further action on the current pixel.
- Latency:
  - Step visible at edge E0 (state→BLANK).
  - we is high in the cycle after edge E0+BLANK_CYCLES+WINDOW_CYCLES+1.
- Timing rule: the scan dwell per pixel must be at least BLANK_CYCLES+WINDOW_CYCLES+3 cycles, so we falls inside the same pixel. Otherwise the step aborts the window and hits are never reported.
- we is never asserted when key_level=0, when en=0, or when the window was aborted.
- Key release mid-window: the decision uses key_level as sampled in DECIDE.
- hit_row/hit_col hold their value until the next qualified hit.

Decomposition:
- Shared package/header (beside led_para.v):
  - FSM state encodings.
  - Defaults for BLANK_CYCLES, WINDOW_CYCLES, HIT_THRESH, DEBOUNCE_CYCLES (derived from CLOCK_FREQ, targeting 1 ms).
  - One-hot-to-binary encode function.
- Sub-module pen_debounce: synchroniser plus stability counter, parameter DEBOUNCE_CYCLES. Instantiated once, for the key.
- The sensor uses only the synchroniser, inline.

Test Plan (BLANK=2, WINDOW=8, THRESH=6, DEBOUNCE=4, dwell=20):
- Reset: hold rst 3 cycles with pen inputs toggling → all outputs 0, FSM IDLE. After release, no we until the first step.
- Hit: key held ≥6 cycles, sensor high throughout dwell of row=0x04, col=0x10 → exactly one we/hit_valid pulse 11 cycles after the step, with hit_row=2, hit_col=4.
- Threshold boundary: sensor high for exactly 6 of 8 window samples → hit. Exactly 5 → no we. hit_row/hit_col keep their prior value.
- Key gating/debounce: sensor always high, key bouncing with 3-cycle pulses → key_level stays 0 and no we. Then a 4-cycle stable press → key_level=1 and hits resume on the next pixel.
- Abort: step occurs 6 cycles after the previous step (mid-SAMPLE) → no we for the old pixel. The new pixel is evaluated normally.
- Disable/invalid: en=0, or led_col=0x18 (not one-hot), with pen and key active → no we. The FSM returns to IDLE within one cycle.
